// File: rtl/zx_rom_loader.sv
// zx_rom_loader: boot-time loader for the ZX ROM image held in one SPRAM.
// Packs a flash byte stream little-endian into 16-bit words, writes them to
// the ROM wrapper, then hands the ROM port to the CPU for byte reads.
// Optional feature macro: ZX_ROM_CHECKSUM_EN (8-bit modular byte checksum).
module zx_rom_loader #(
    parameter int         ROM_BYTES = 16384,
    parameter logic [7:0] EXP_SUM   = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        ram_wen_o,
    output logic [13:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    input  logic        cpu_rd_i,
    input  logic [13:0] cpu_addr_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_ack_o,
    output logic        cpu_wait_o,
    output logic        loaded_o,
    output logic [7:0]  sum_o,
    output logic        sum_ok_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_LO = 3'd1,
        S_LOAD_HI = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Loading terminates on this index; the counter never wraps.
    localparam logic [12:0] LAST_WORD = 13'(ROM_BYTES / 2 - 1);

    state_t      state_q, state_d;
    logic [12:0] wcnt_q, wcnt_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        in_ready_q, ram_wen_q, loaded_q, cpu_wait_q;
    logic        accept_s, clear_s, finish_s;

    assign accept_s = in_valid_i && in_ready_q;
    assign clear_s  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign finish_s = (state_q == S_WRITE) && (wcnt_q == LAST_WORD);

    // Next-state, word counter, byte packing and CPU read acknowledge.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD_LO;
                    wcnt_d  = 13'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_LO: begin
                if (accept_s) begin
                    wdata_d[7:0] = in_data_i;
                    state_d      = S_LOAD_HI;
                end else begin
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_HI: begin
                if (accept_s) begin
                    wdata_d[15:8] = in_data_i;
                    state_d       = S_WRITE;
                end else begin
                    state_d = S_LOAD_HI;
                end
            end
            S_WRITE: begin
                if (finish_s) begin
                    state_d = S_DONE;
                end else begin
                    wcnt_d  = wcnt_q + 13'd1;
                    state_d = S_LOAD_LO;
                end
            end
            S_DONE: begin
                // A restart takes priority over a coincident CPU read.
                if (start_i) begin
                    state_d = S_LOAD_LO;
                    wcnt_d  = 13'd0;
                end else if (cpu_rd_i) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 13'd0;
            wdata_q    <= 16'd0;
            ack_q      <= 1'b0;
            in_ready_q <= 1'b0;
            ram_wen_q  <= 1'b0;
            loaded_q   <= 1'b0;
            cpu_wait_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            in_ready_q <= (state_d == S_LOAD_LO) || (state_d == S_LOAD_HI);
            ram_wen_q  <= (state_d == S_WRITE);
            loaded_q   <= (state_d == S_DONE);
            cpu_wait_q <= (state_d != S_DONE);
        end
    end

    // ROM address: word index while writing, CPU byte address once loaded.
    always_comb begin
        ram_addr_o = 14'd0;
        if (ram_wen_q) begin
            ram_addr_o = {1'b0, wcnt_q};
        end else if (loaded_q) begin
            ram_addr_o = cpu_addr_i;
        end else begin
            ram_addr_o = 14'd0;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign ram_wen_o   = ram_wen_q;
    assign ram_wdata_o = wdata_q;
    assign cpu_data_o  = ram_rdata_i;
    assign cpu_ack_o   = ack_q;
    assign cpu_wait_o  = cpu_wait_q;
    assign loaded_o    = loaded_q;

`ifdef ZX_ROM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       sum_ok_q, sum_ok_d;

    // Running byte sum; verdict captured as the last word is written.
    always_comb begin
        sum_d    = sum_q;
        sum_ok_d = sum_ok_q;
        if (clear_s) begin
            sum_d    = 8'd0;
            sum_ok_d = 1'b0;
        end else if (accept_s) begin
            sum_d = sum_q + in_data_i;
        end else if (finish_s) begin
            sum_ok_d = (sum_q == EXP_SUM);
        end else begin
            sum_d    = sum_q;
            sum_ok_d = sum_ok_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q    <= 8'd0;
            sum_ok_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            sum_ok_q <= sum_ok_d;
        end
    end

    assign sum_o    = sum_q;
    assign sum_ok_o = sum_ok_q;
`else
    logic [7:0] unused_exp_sum_s;

    assign unused_exp_sum_s = EXP_SUM;
    assign sum_o            = 8'd0;
    assign sum_ok_o         = 1'b1;
`endif

endmodule

// File: tb/tb_zx_rom_loader.sv
// Bench for zx_rom_loader: SPRAM wrapper model, per-cycle behavioural
// checker and directed load/read/restart scenarios.
// Honours ZX_ROM_CHECKSUM_EN the same way the design does.
module tb_zx_rom_loader;

    localparam int         N   = 16384;
    localparam logic [7:0] EXP = 8'h00;

    logic        clk, reset, start, in_valid, in_ready, ram_wen;
    logic [7:0]  in_data, ram_rdata, cpu_data, sum;
    logic [13:0] ram_addr, cpu_addr;
    logic [15:0] ram_wdata;
    logic        cpu_rd, cpu_ack, cpu_wait, loaded, sum_ok;

    zx_rom_loader #(.ROM_BYTES(N), .EXP_SUM(EXP)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ram_wen_o(ram_wen), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .cpu_rd_i(cpu_rd), .cpu_addr_i(cpu_addr),
        .cpu_data_o(cpu_data), .cpu_ack_o(cpu_ack), .cpu_wait_o(cpu_wait),
        .loaded_o(loaded), .sum_o(sum), .sum_ok_o(sum_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPRAM wrapper: word writes, registered byte-selected read.
    logic [15:0] mem [0:8191];
    logic [7:0]  rdata_q = 8'd0;
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr[12:0]] <= ram_wdata;
        rdata_q <= ram_addr[0] ? mem[ram_addr[13:1]][15:8] : mem[ram_addr[13:1]][7:0];
    end
    assign ram_rdata = rdata_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes taken, words written, completion, reads.
    bit          m_loading = 1'b0, m_done = 1'b0, m_ack = 1'b0, m_sumok = 1'b0;
    bit          m_pend, m_rdy;
    int          m_nacc = 0, m_nwr = 0;
    logic [13:0] m_ack_addr = 14'd0;
    logic [7:0]  m_sum = 8'd0;
    logic [7:0]  img [0:N-1];

    always @(negedge clk) begin
        // A word is owed once a complete pair has arrived and not been written.
        m_pend = m_loading && (m_nacc > 0) && (m_nacc % 2 == 0) && (m_nwr < m_nacc / 2);
        m_rdy  = m_loading && !m_pend && (m_nacc < N);
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        check("ram_wen", 32'(ram_wen), 32'(m_pend));
        if (m_pend) begin
            check("wr_addr", 32'(ram_addr), 32'(m_nwr));
            check("wr_data", 32'(ram_wdata), 32'({img[2*m_nwr+1], img[2*m_nwr]}));
        end
        check("loaded", 32'(loaded), 32'(m_done));
        check("cpu_wait", 32'(cpu_wait), 32'(!m_done));
        if (m_done) check("rd_addr", 32'(ram_addr), 32'(cpu_addr));
        check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
        if (m_ack) check("cpu_data", 32'(cpu_data), 32'(img[m_ack_addr]));
`ifdef ZX_ROM_CHECKSUM_EN
        check("sum", 32'(sum), 32'(m_sum));
        check("sum_ok", 32'(sum_ok), 32'(m_sumok));
`else
        check("sum_tied", 32'(sum), 32'd0);
        check("sum_ok_tied", 32'(sum_ok), 32'd1);
`endif
        if (reset) begin
            m_loading = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_sumok = 1'b0;
            m_nacc = 0; m_nwr = 0; m_sum = 8'd0;
        end else begin
            m_ack      = m_done && cpu_rd && !start;
            m_ack_addr = cpu_addr;
            if (m_pend) begin
                m_nwr++;
                if (m_nwr == N / 2) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                    m_sumok   = (m_sum == EXP);
                end
            end else if (m_rdy && in_valid) begin
                img[m_nacc] = in_data;
                m_nacc++;
                m_sum = m_sum + in_data;
            end else if (start && !m_loading) begin
                m_loading = 1'b1; m_done = 1'b0; m_sumok = 1'b0;
                m_nacc = 0; m_nwr = 0; m_sum = 8'd0;
            end
        end
    end

    int t0 = 0;

    // Stream n bytes of i[7:0] (one optionally forced to 0xFF), optional gaps.
    task automatic send(input int n, input bit gaps, input int bad_idx, input bit meas);
        bit got;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && (i % 7 == 0)) begin
                in_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = (i == bad_idx) ? 8'hFF : 8'(i);
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    if (meas && i == 0) t0 = cyc;
                end
                @(posedge clk);
                #1;
            end
            if (!got) begin
                check("handshake_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_loaded(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (loaded) seen = 1'b1;
        end
        check("loaded_seen", 32'(seen), 32'd1);
    endtask

    task automatic cpu_read(input logic [13:0] a, input logic [7:0] exp_byte);
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = a;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        @(negedge clk);
        check("rd_ack", 32'(cpu_ack), 32'd1);
        check("rd_byte", 32'(cpu_data), 32'(exp_byte));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        cpu_rd = 1'b0; cpu_addr = 14'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd1);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
`ifdef ZX_ROM_CHECKSUM_EN
        check("rst_sum_ok", 32'(sum_ok), 32'd0);
`endif

        // Full load, no gaps, CPU trying to read throughout.
        @(posedge clk); #1;
        start = 1'b1; cpu_rd = 1'b1; cpu_addr = 14'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("load_no_ack", 32'(cpu_ack), 32'd0);
        check("load_wait", 32'(cpu_wait), 32'd1);
        @(posedge clk); #1;
        send(N, 1'b0, -1, 1'b1);
        cpu_rd = 1'b0;
        wait_loaded(seen);
        check("load_latency", 32'(cyc - t0), 32'd24576);
        check("mem_word0", 32'(mem[0]), 32'h0100);
        check("mem_word1", 32'(mem[1]), 32'h0302);
        check("mem_word_last", 32'(mem[8191]), 32'hFFFE);
`ifdef ZX_ROM_CHECKSUM_EN
        check("sum_clean", 32'(sum), 32'h00);
        check("sum_ok_clean", 32'(sum_ok), 32'd1);
`endif
        cpu_read(14'h0001, 8'h01);
        cpu_read(14'h3FFF, 8'hFF);
        cpu_read(14'h0100, 8'h00);

        // Restart coincident with a CPU read.
        @(posedge clk); #1;
        start = 1'b1; cpu_rd = 1'b1; cpu_addr = 14'h0001;
        @(posedge clk); #1;
        start = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        check("restart_no_ack", 32'(cpu_ack), 32'd0);
        check("restart_wait", 32'(cpu_wait), 32'd1);
        check("restart_loaded", 32'(loaded), 32'd0);

        // Abort mid-load with reset after 1000 bytes.
        @(posedge clk); #1;
        send(1000, 1'b1, -1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_loaded", 32'(loaded), 32'd0);
        check("abort_wait", 32'(cpu_wait), 32'd1);
        check("abort_wen", 32'(ram_wen), 32'd0);

        // Full gapped load with byte 5 corrupted to 0xFF.
        pulse_start();
        send(N, 1'b1, 5, 1'b0);
        wait_loaded(seen);
`ifdef ZX_ROM_CHECKSUM_EN
        check("sum_bad", 32'(sum), 32'hFA);
        check("sum_ok_bad", 32'(sum_ok), 32'd0);
`endif
        check("mem2_word0", 32'(mem[0]), 32'h0100);
        check("mem2_word2", 32'(mem[2]), 32'hFF04);
        cpu_read(14'h0001, 8'h01);
        cpu_read(14'h0005, 8'hFF);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zx_rom_loader.md
# zx_rom_loader

Boot-time loader and access sequencer for the ZX ROM held in a single UP5K SPRAM. After reset or a `start` pulse it accepts a byte stream from the flash reader, packs byte pairs little-endian into 16-bit words and writes them to the ROM wrapper. Once the image is complete it hands the ROM port to the Z80 side for byte reads. It sits between the flash/SPI reader, the ROM wrapper (`wen`, `addr`, `wdata`, `rdata`) and the CPU memory decoder, and holds the CPU off via `cpu_wait` while loading.

## Interface
- `ROM_BYTES`, 16384: image size in bytes; even, at most 16384.
- `EXP_SUM`, 8'h00: expected 8-bit modular byte sum; used only when the checksum feature is compiled in.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; begins (re)load from `IDLE` or `DONE`; ignored while loading.
- `in_data` in 8: stream byte from the flash reader.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts a byte this cycle when high together with `in_valid`.
- `ram_wen` out 1: write strobe to the ROM wrapper.
- `ram_addr` out 14: during a write, the word index in [12:0] with bit 13 = 0; otherwise the CPU byte address.
- `ram_wdata` out 16: packed word, with the first byte in [7:0] and the second in [15:8].
- `ram_rdata` in 8: byte-selected read data from the ROM wrapper.
- `cpu_rd` in 1: CPU read strobe, honoured only in `DONE`.
- `cpu_addr` in 14: CPU byte address.
- `cpu_data` out 8: read byte.
- `cpu_ack` out 1: `cpu_data` valid this cycle.
- `cpu_wait` out 1: CPU must stall.
- `loaded` out 1: image complete.
- `sum` out 8: running byte checksum.
- `sum_ok` out 1: checksum matched.

## Operation
- States: `IDLE`, `LOAD_LO`, `LOAD_HI`, `WRITE`, `DONE`.
- `IDLE`
  - `start` leads to `LOAD_LO`; clears the word counter `wcnt` (13 bit) and `sum`.
- `LOAD_LO`
  - `in_ready` = 1.
  - On a handshake, the byte is latched into `ram_wdata[7:0]`; next state `LOAD_HI`.
- `LOAD_HI`
  - `in_ready` = 1.
  - On a handshake, the byte is latched into `ram_wdata[15:8]`; next state `WRITE`.
- `WRITE`
  - Drives `ram_wen` = 1 and `ram_addr` = {1'b0, `wcnt`} for exactly one cycle.
  - If `wcnt` == `ROM_BYTES`/2−1, go to `DONE`; otherwise increment `wcnt` and go to `LOAD_LO`.
- `DONE`
  - `loaded` = 1, `cpu_wait` = 0, `ram_wen` = 0, `ram_addr` = `cpu_addr`.
  - `start` returns to `LOAD_LO` with the counter and `sum` cleared, and `loaded` dropped.
- `cpu_wait` = 1 in every state except `DONE`.
- `cpu_rd` outside `DONE` is ignored: no `cpu_ack`.
- `in_valid` outside the `LOAD_*` states is ignored, and `in_ready` = 0 there.
- Bytes beyond `ROM_BYTES` are never accepted.
- `wcnt` never wraps. Termination is by compare, so `ROM_BYTES` = 16384 ends at index 8191.
- `start` and `cpu_rd` in the same `DONE` cycle: `start` wins, no `cpu_ack` is issued, and `cpu_wait` rises the next cycle.
- `reset` at any time, including mid-load, gives `IDLE` on the next edge with a partial image discarded.

## Timing
- Reset values:
  - state `IDLE`; `in_ready` 0; `ram_wen` 0; `ram_addr` 0; `ram_wdata` 0.
  - `cpu_ack` 0; `cpu_data` = `ram_rdata` passthrough; `cpu_wait` 1; `loaded` 0.
  - `sum` 0; `sum_ok` 0.
- Load throughput is 3 cycles per word at minimum (LO, HI, WRITE).
- A full 16 KB load takes at least 24576 cycles after `start`, plus any `in_valid` gaps.
- `loaded` and `cpu_wait` = 0 become visible on the cycle after the final `WRITE`.
- CPU read:
  - The CPU asserts `cpu_rd` with `cpu_addr` in cycle N and holds `cpu_addr` through N+1.
  - `cpu_ack` = 1 and `cpu_data` are valid in N+1, because the SPRAM read is registered.
  - Back-to-back reads achieve one per cycle only if each address is held for its ack cycle; otherwise one per 2 cycles.
- `in_valid` may drop at any cycle. The state holds with no timeout.

## Configuration
- `ZX_ROM_CHECKSUM_EN` defined:
  - `sum` accumulates every accepted byte mod 256.
  - `sum_ok` is registered as (`sum` == `EXP_SUM`) on entry to `DONE`, and cleared on `start` and on `reset`.
- Not defined:
  - `sum` is tied to 0 and `sum_ok` is tied to 1.
  - No adder or compare is synthesised.

## Test plan
- Reset, `start`, then 16384 bytes with byte[i] = i[7:0] and `in_valid` always high:
  - write k has `ram_addr` = k and `ram_wdata` = {(2k+1)[7:0], (2k)[7:0]};
  - `loaded` rises exactly 24576 cycles after the first accept.
- Same stream with `in_valid` deasserted for 5 cycles every 7th byte: identical writes, no byte lost or duplicated, `in_ready` never high in `WRITE`.
- After `DONE`:
  - `cpu_rd` at `cpu_addr` 0x0001 gives `cpu_ack` next cycle with `cpu_data` = 0x01;
  - `cpu_rd` during load gives no ack and `cpu_wait` = 1.
- `reset` after 1000 bytes, then `start` plus a full stream: state `IDLE` 1 cycle post-reset, `wcnt` restarts at 0, `loaded` only after the complete second image.
- With `ZX_ROM_CHECKSUM_EN` and `EXP_SUM` = 8'h00, byte[i] = i[7:0]: `sum` = 0x00 and `sum_ok` = 1. Corrupting one byte to 0xFF gives `sum_ok` = 0.
- `start` coincident with `cpu_rd` in `DONE`: no `cpu_ack`, `cpu_wait` = 1 next cycle, `loaded` = 0.
